button_event_decoder: RTL

//   Consumes the clean level from the debouncer and turns it into one-cycle

---
 rtl/button_event_decoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered one-cycle events: press, release,
// single click, double click and long press. The falling-edge pulse is named release_pulse
// because "release" is a reserved word in SystemVerilog.
module button_event_decoder #(
  parameter int LONG_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic held,
  output logic press,
  output logic release_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press
);

  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DOWN1, WAIT2, DOWN2, LONG} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             rise, fall;

  assign rise = in & ~in_q;
  assign fall = ~in & in_q;

  // Edges take priority over the counter expiry tested on the same clock.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = rise;
    release_d = fall;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = DOWN1;
          cnt_d   = '0;
        end
      end
      DOWN1: begin
        if (fall) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = DOWN2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN2: begin
        cnt_d = '0;
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      in_q      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_q      <= in;
      press_q   <= press_d;
      release_q <= release_d;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  assign held          = in_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign single_click  = single_q;
  assign double_click  = double_q;
  assign long_press    = long_q;

endmodule
